// File: rtl/alu_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue_pkg
// Description : Shared types and default sizing for the ALU issue queue and
//               its select logic.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_queue_pkg;

    localparam int ALU_IQ_DEPTH  = 8;
    localparam int ALU_IQ_PREG_W = 6;
    localparam int ALU_IQ_OC_W   = 32;
    localparam int ALU_IQ_WK_N   = 2;

    // One queue slot at default sizing.
    typedef struct packed {
        logic                     valid;
        logic [ALU_IQ_PREG_W-1:0] pdest;
        logic [ALU_IQ_PREG_W-1:0] psrc0;
        logic                     rdy0;
        logic [ALU_IQ_PREG_W-1:0] psrc1;
        logic                     rdy1;
        logic [ALU_IQ_OC_W-1:0]   oc;
    } AluIqEntrySt;

    // Payload handed to the regfile-read / execute stage.
    typedef struct packed {
        logic [ALU_IQ_PREG_W-1:0] pdest;
        logic [ALU_IQ_PREG_W-1:0] psrc0;
        logic [ALU_IQ_PREG_W-1:0] psrc1;
        logic [ALU_IQ_OC_W-1:0]   oc;
    } AluIssueSt;

endpackage
`default_nettype wire

// File: rtl/alu_iq_select.sv
`default_nettype none
// ============================================================================
// Module      : alu_iq_select
// Description : Lowest-index priority picker. Returns a one-hot grant, an
//               any-request flag and the binary index of the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iq_select #(
    parameter  int DEPTH = 8,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] i_req,
    output logic [DEPTH-1:0] o_grant,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the last hit (the lowest index) wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
            end
        end
    end

    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue
// Description : Collapsing, age-ordered ALU issue queue. Entry 0 is oldest;
//               valid entries stay packed from index 0. Sources are woken by
//               writeback broadcasts and the oldest fully-ready entry is
//               offered downstream over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter  int DEPTH  = ALU_IQ_DEPTH,
    parameter  int PREG_W = ALU_IQ_PREG_W,
    parameter  int OC_W   = ALU_IQ_OC_W,
    parameter  int WK_N   = ALU_IQ_WK_N,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   s_rst,
    input  logic                   flush_i,
    input  logic                   dis_valid_i,
    output logic                   dis_ready_o,
    input  logic [PREG_W-1:0]      dis_pdest_i,
    input  logic [PREG_W-1:0]      dis_psrc0_i,
    input  logic [PREG_W-1:0]      dis_psrc1_i,
    input  logic                   dis_rdy0_i,
    input  logic                   dis_rdy1_i,
    input  logic [OC_W-1:0]        dis_oc_i,
    input  logic [WK_N-1:0]        wk_valid_i,
    input  logic [WK_N*PREG_W-1:0] wk_preg_i,
    output logic                   iss_valid_o,
    input  logic                   iss_ready_i,
    output logic [PREG_W-1:0]      iss_pdest_o,
    output logic [PREG_W-1:0]      iss_psrc0_o,
    output logic [PREG_W-1:0]      iss_psrc1_o,
    output logic [OC_W-1:0]        iss_oc_o,
    output logic [CNT_W-1:0]       count_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Registered queue state.
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_rdy0;
    logic [DEPTH-1:0]  r_rdy1;
    logic [PREG_W-1:0] r_pdest [DEPTH];
    logic [PREG_W-1:0] r_psrc0 [DEPTH];
    logic [PREG_W-1:0] r_psrc1 [DEPTH];
    logic [OC_W-1:0]   r_oc    [DEPTH];
    logic [CNT_W-1:0]  r_count;

    // Contents of slot i+1, i.e. what slot i holds after a collapse.
    logic [DEPTH-1:0]  w_up_valid;
    logic [DEPTH-1:0]  w_up_rdy0;
    logic [DEPTH-1:0]  w_up_rdy1;
    logic [PREG_W-1:0] w_up_pdest [DEPTH];
    logic [PREG_W-1:0] w_up_psrc0 [DEPTH];
    logic [PREG_W-1:0] w_up_psrc1 [DEPTH];
    logic [OC_W-1:0]   w_up_oc    [DEPTH];

    // Next-state.
    logic [DEPTH-1:0]  w_nxt_valid;
    logic [DEPTH-1:0]  w_nxt_rdy0;
    logic [DEPTH-1:0]  w_nxt_rdy1;
    logic [PREG_W-1:0] w_nxt_pdest [DEPTH];
    logic [PREG_W-1:0] w_nxt_psrc0 [DEPTH];
    logic [PREG_W-1:0] w_nxt_psrc1 [DEPTH];
    logic [OC_W-1:0]   w_nxt_oc    [DEPTH];
    logic [CNT_W-1:0]  w_nxt_count;

    logic [DEPTH-1:0]  w_req;
    logic [DEPTH-1:0]  w_sel_oh;
    logic              w_sel_valid;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_iss_fire;
    logic              w_dis_fire;
    logic [CNT_W-1:0]  w_dis_idx;
    logic              w_dis_wk0;
    logic              w_dis_wk1;

    // True when any active wakeup port broadcasts the given preg.
    function automatic logic f_wake(
        input logic [PREG_W-1:0]      preg,
        input logic [WK_N-1:0]        vld,
        input logic [WK_N*PREG_W-1:0] pregs
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WK_N; k++) begin
            if (vld[k] && (pregs[k*PREG_W +: PREG_W] == preg)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Shift-source wiring; the top slot has nothing above it and empties.
    for (genvar g = 0; g < DEPTH; g++) begin : g_up
        if (g < DEPTH - 1) begin : g_mid
            assign w_up_valid[g] = r_valid[g+1];
            assign w_up_rdy0[g]  = r_rdy0[g+1];
            assign w_up_rdy1[g]  = r_rdy1[g+1];
            assign w_up_pdest[g] = r_pdest[g+1];
            assign w_up_psrc0[g] = r_psrc0[g+1];
            assign w_up_psrc1[g] = r_psrc1[g+1];
            assign w_up_oc[g]    = r_oc[g+1];
        end else begin : g_last
            assign w_up_valid[g] = 1'b0;
            assign w_up_rdy0[g]  = r_rdy0[g];
            assign w_up_rdy1[g]  = r_rdy1[g];
            assign w_up_pdest[g] = r_pdest[g];
            assign w_up_psrc0[g] = r_psrc0[g];
            assign w_up_psrc1[g] = r_psrc1[g];
            assign w_up_oc[g]    = r_oc[g];
        end
    end

    assign w_req = r_valid & r_rdy0 & r_rdy1;

    alu_iq_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .i_req   (w_req),
        .o_grant (w_sel_oh),
        .o_valid (w_sel_valid),
        .o_idx   (w_sel_idx)
    );

    // One-hot AND-OR mux of the selected entry onto the issue port.
    always_comb begin
        iss_pdest_o = '0;
        iss_psrc0_o = '0;
        iss_psrc1_o = '0;
        iss_oc_o    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            iss_pdest_o = iss_pdest_o | ({PREG_W{w_sel_oh[i]}} & r_pdest[i]);
            iss_psrc0_o = iss_psrc0_o | ({PREG_W{w_sel_oh[i]}} & r_psrc0[i]);
            iss_psrc1_o = iss_psrc1_o | ({PREG_W{w_sel_oh[i]}} & r_psrc1[i]);
            iss_oc_o    = iss_oc_o    | ({OC_W{w_sel_oh[i]}}   & r_oc[i]);
        end
    end

    assign iss_valid_o = w_sel_valid;
    assign count_o     = r_count;
    // A slot freed by a same-cycle issue is not offered to dispatch.
    assign dis_ready_o = (r_count < CNT_W'(DEPTH));
    assign w_iss_fire  = w_sel_valid & iss_ready_i & ~flush_i;
    assign w_dis_fire  = dis_valid_i & dis_ready_o & ~flush_i;
    // Landing slot accounts for the collapse caused by a same-cycle issue.
    assign w_dis_idx   = r_count - CNT_W'(w_iss_fire);
    assign w_dis_wk0   = dis_rdy0_i | f_wake(dis_psrc0_i, wk_valid_i, wk_preg_i);
    assign w_dis_wk1   = dis_rdy1_i | f_wake(dis_psrc1_i, wk_valid_i, wk_preg_i);

    // Next state: collapse above the issued slot, wake in post-shift place,
    // then drop the dispatched op into the first free slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_iss_fire && (i >= int'(w_sel_idx))) begin
                w_nxt_valid[i] = w_up_valid[i];
                w_nxt_rdy0[i]  = w_up_rdy0[i];
                w_nxt_rdy1[i]  = w_up_rdy1[i];
                w_nxt_pdest[i] = w_up_pdest[i];
                w_nxt_psrc0[i] = w_up_psrc0[i];
                w_nxt_psrc1[i] = w_up_psrc1[i];
                w_nxt_oc[i]    = w_up_oc[i];
            end else begin
                w_nxt_valid[i] = r_valid[i];
                w_nxt_rdy0[i]  = r_rdy0[i];
                w_nxt_rdy1[i]  = r_rdy1[i];
                w_nxt_pdest[i] = r_pdest[i];
                w_nxt_psrc0[i] = r_psrc0[i];
                w_nxt_psrc1[i] = r_psrc1[i];
                w_nxt_oc[i]    = r_oc[i];
            end

            w_nxt_rdy0[i] = w_nxt_rdy0[i] | f_wake(w_nxt_psrc0[i], wk_valid_i, wk_preg_i);
            w_nxt_rdy1[i] = w_nxt_rdy1[i] | f_wake(w_nxt_psrc1[i], wk_valid_i, wk_preg_i);

            if (w_dis_fire && (CNT_W'(i) == w_dis_idx)) begin
                w_nxt_valid[i] = 1'b1;
                w_nxt_rdy0[i]  = w_dis_wk0;
                w_nxt_rdy1[i]  = w_dis_wk1;
                w_nxt_pdest[i] = dis_pdest_i;
                w_nxt_psrc0[i] = dis_psrc0_i;
                w_nxt_psrc1[i] = dis_psrc1_i;
                w_nxt_oc[i]    = dis_oc_i;
            end
        end

        w_nxt_count = r_count + CNT_W'(w_dis_fire) - CNT_W'(w_iss_fire);

        if (flush_i) begin
            w_nxt_valid = '0;
            w_nxt_count = '0;
        end
    end

    // Occupancy state; reset and flush empty the queue.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_nxt_valid;
            r_count <= w_nxt_count;
        end
    end

    // Payload and ready bits; meaningless while the slot is invalid.
    always_ff @(posedge clk) begin
        r_rdy0 <= w_nxt_rdy0;
        r_rdy1 <= w_nxt_rdy1;
        for (int i = 0; i < DEPTH; i++) begin
            r_pdest[i] <= w_nxt_pdest[i];
            r_psrc0[i] <= w_nxt_psrc0[i];
            r_psrc1[i] <= w_nxt_psrc1[i];
            r_oc[i]    <= w_nxt_oc[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_queue
// Description : Directed, table-driven bench for alu_issue_queue. Each row
//               is one clock cycle: inputs driven after the edge, outputs
//               compared mid-cycle against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;

    localparam int DEPTH  = 8;
    localparam int PREG_W = 6;
    localparam int OC_W   = 32;
    localparam int WK_N   = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                   clk;
    logic                   s_rst;
    logic                   flush_i;
    logic                   dis_valid_i;
    logic                   dis_ready_o;
    logic [PREG_W-1:0]      dis_pdest_i;
    logic [PREG_W-1:0]      dis_psrc0_i;
    logic [PREG_W-1:0]      dis_psrc1_i;
    logic                   dis_rdy0_i;
    logic                   dis_rdy1_i;
    logic [OC_W-1:0]        dis_oc_i;
    logic [WK_N-1:0]        wk_valid_i;
    logic [WK_N*PREG_W-1:0] wk_preg_i;
    logic                   iss_valid_o;
    logic                   iss_ready_i;
    logic [PREG_W-1:0]      iss_pdest_o;
    logic [PREG_W-1:0]      iss_psrc0_o;
    logic [PREG_W-1:0]      iss_psrc1_o;
    logic [OC_W-1:0]        iss_oc_o;
    logic [CNT_W-1:0]       count_o;

    alu_issue_queue #(
        .DEPTH  (DEPTH),
        .PREG_W (PREG_W),
        .OC_W   (OC_W),
        .WK_N   (WK_N)
    ) dut (
        .clk         (clk),
        .s_rst       (s_rst),
        .flush_i     (flush_i),
        .dis_valid_i (dis_valid_i),
        .dis_ready_o (dis_ready_o),
        .dis_pdest_i (dis_pdest_i),
        .dis_psrc0_i (dis_psrc0_i),
        .dis_psrc1_i (dis_psrc1_i),
        .dis_rdy0_i  (dis_rdy0_i),
        .dis_rdy1_i  (dis_rdy1_i),
        .dis_oc_i    (dis_oc_i),
        .wk_valid_i  (wk_valid_i),
        .wk_preg_i   (wk_preg_i),
        .iss_valid_o (iss_valid_o),
        .iss_ready_i (iss_ready_i),
        .iss_pdest_o (iss_pdest_o),
        .iss_psrc0_o (iss_psrc0_o),
        .iss_psrc1_o (iss_psrc1_o),
        .iss_oc_o    (iss_oc_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              fl;
        logic              dv;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] s0;
        logic              r0;
        logic [PREG_W-1:0] s1;
        logic              r1;
        logic [WK_N-1:0]   wkv;
        logic [PREG_W-1:0] wk0;
        logic [PREG_W-1:0] wk1;
        logic              ir;
        logic              edr;
        logic              eiv;
        logic [PREG_W-1:0] epd;
        logic [PREG_W-1:0] es0;
        logic [PREG_W-1:0] es1;
        logic [CNT_W-1:0]  ecnt;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Opcode bundle tied to pdest so the payload path can be checked too.
    function automatic logic [OC_W-1:0] oc_of(input logic [PREG_W-1:0] pd);
        return 32'hC0DE_0000 | {26'h0, pd} | ({26'h0, pd} << 8);
    endfunction

    task automatic v(input int rst, input int fl, input int dv, input int pd,
                     input int s0, input int r0, input int s1, input int r1,
                     input int wkv, input int wk0, input int wk1, input int ir,
                     input int edr, input int eiv, input int epd, input int es0,
                     input int es1, input int ecnt);
        vec_t t;
        t.rst  = (rst != 0);
        t.fl   = (fl != 0);
        t.dv   = (dv != 0);
        t.pd   = PREG_W'(pd);
        t.s0   = PREG_W'(s0);
        t.r0   = (r0 != 0);
        t.s1   = PREG_W'(s1);
        t.r1   = (r1 != 0);
        t.wkv  = WK_N'(wkv);
        t.wk0  = PREG_W'(wk0);
        t.wk1  = PREG_W'(wk1);
        t.ir   = (ir != 0);
        t.edr  = (edr != 0);
        t.eiv  = (eiv != 0);
        t.epd  = PREG_W'(epd);
        t.es0  = PREG_W'(es0);
        t.es1  = PREG_W'(es1);
        t.ecnt = CNT_W'(ecnt);
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        s_rst       = 1'b1;
        flush_i     = 1'b0;
        dis_valid_i = 1'b0;
        dis_pdest_i = '0;
        dis_psrc0_i = '0;
        dis_psrc1_i = '0;
        dis_rdy0_i  = 1'b0;
        dis_rdy1_i  = 1'b0;
        dis_oc_i    = '0;
        wk_valid_i  = '0;
        wk_preg_i   = '0;
        iss_ready_i = 1'b0;

        //  rst fl dv  pd s0 r0 s1 r1 wkv wk0 wk1 ir | edr eiv epd es0 es1 cnt
        // In-order issue of always-ready ops, then dispatch+issue same cycle.
        v(0,0,1,  1, 1,1, 2,1, 0, 0,0, 1,  1,0,  0, 0, 0, 0);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1,  1, 1, 2, 1);
        v(0,0,1,  2, 3,1, 4,1, 0, 0,0, 1,  1,0,  0, 0, 0, 0);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1,  2, 3, 4, 1);
        v(0,0,1,  3, 5,1, 6,1, 0, 0,0, 1,  1,0,  0, 0, 0, 0);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1,  3, 5, 6, 1);
        v(0,0,1,  4, 7,1, 8,1, 0, 0,0, 1,  1,0,  0, 0, 0, 0);
        v(0,0,1,  5, 9,1,10,1, 0, 0,0, 1,  1,1,  4, 7, 8, 1);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1,  5, 9,10, 1);
        // Younger ready op overtakes; wakeup selectable one cycle later.
        v(0,0,1, 10, 5,0, 6,1, 0, 0,0, 0,  1,0,  0, 0, 0, 0);
        v(0,0,1, 11, 7,1, 8,1, 0, 0,0, 0,  1,0,  0, 0, 0, 1);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1, 11, 7, 8, 2);
        v(0,0,0,  0, 0,0, 0,0, 1, 5,0, 1,  1,0,  0, 0, 0, 1);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1, 10, 5, 6, 1);
        // Dispatch-cycle wakeup bypass, mismatched port, preg 0 wakes.
        v(0,0,1, 12, 3,1, 9,0, 2, 0,9, 1,  1,0,  0, 0, 0, 0);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1, 12, 3, 9, 1);
        v(0,0,1, 13, 0,0, 9,1, 2, 0,8, 1,  1,0,  0, 0, 0, 0);
        v(0,0,0,  0, 0,0, 0,0, 1, 0,0, 1,  1,0,  0, 0, 0, 1);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1, 13, 0, 9, 1);
        // Fill with blocked ops.
        for (int i = 0; i < 8; i++) begin
            v(0,0,1, 20+i, 40+i,0, 60+i,1, 0, 0,0, 1,  1,0, 0, 0, 0, i);
        end
        // Full: dispatch refused; wake entry 3, issue it, new op lands at 7.
        v(0,0,1, 30, 1,1, 2,1, 1,43,0, 1,  0,0,  0, 0, 0, 8);
        v(0,0,1, 30, 1,1, 2,1, 0, 0,0, 1,  0,1, 23,43,63, 8);
        v(0,0,1, 30, 1,1, 2,1, 0, 0,0, 0,  1,0,  0, 0, 0, 7);
        v(0,0,0,  0, 0,0, 0,0, 3,44,47, 0,  0,1, 30, 1, 2, 8);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 0,  0,1, 24,44,64, 8);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  0,1, 24,44,64, 8);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1, 27,47,67, 7);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1, 30, 1, 2, 6);
        // Backpressure holds entry 2; then 2 and the collapsed 5 issue.
        v(0,0,0,  0, 0,0, 0,0, 3,42,46, 0,  1,0,  0, 0, 0, 5);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 0,  1,1, 22,42,62, 5);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 0,  1,1, 22,42,62, 5);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1, 22,42,62, 5);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,1, 26,46,66, 4);
        // Back to 5 entries with one ready, then flush with dispatch+issue.
        v(0,0,1, 31,50,0,52,1, 0, 0,0, 0,  1,0,  0, 0, 0, 3);
        v(0,0,1, 32,51,0,53,1, 1,40,0, 0,  1,0,  0, 0, 0, 4);
        v(0,1,1, 33, 1,1, 2,1, 0, 0,0, 1,  1,1, 20,40,60, 5);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,0,  0, 0, 0, 0);
        // Refill 5 entries, then reset with dispatch+issue.
        v(0,0,1, 34,11,1,12,1, 0, 0,0, 0,  1,0,  0, 0, 0, 0);
        v(0,0,1, 35,11,1,12,1, 0, 0,0, 0,  1,1, 34,11,12, 1);
        v(0,0,1, 36,11,1,12,1, 0, 0,0, 0,  1,1, 34,11,12, 2);
        v(0,0,1, 37,11,1,12,1, 0, 0,0, 0,  1,1, 34,11,12, 3);
        v(0,0,1, 38,11,1,12,1, 0, 0,0, 0,  1,1, 34,11,12, 4);
        v(1,0,1, 39,11,1,12,1, 0, 0,0, 1,  1,1, 34,11,12, 5);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,0,  0, 0, 0, 0);
        v(0,0,0,  0, 0,0, 0,0, 0, 0,0, 1,  1,0,  0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[n]) begin
            s_rst       = tbl[n].rst;
            flush_i     = tbl[n].fl;
            dis_valid_i = tbl[n].dv;
            dis_pdest_i = tbl[n].pd;
            dis_psrc0_i = tbl[n].s0;
            dis_rdy0_i  = tbl[n].r0;
            dis_psrc1_i = tbl[n].s1;
            dis_rdy1_i  = tbl[n].r1;
            dis_oc_i    = oc_of(tbl[n].pd);
            wk_valid_i  = tbl[n].wkv;
            wk_preg_i   = {tbl[n].wk1, tbl[n].wk0};
            iss_ready_i = tbl[n].ir;
            #3;
            chk("dis_ready", n, 32'(dis_ready_o), 32'(tbl[n].edr));
            chk("iss_valid", n, 32'(iss_valid_o), 32'(tbl[n].eiv));
            chk("count",     n, 32'(count_o),     32'(tbl[n].ecnt));
            if (tbl[n].eiv) begin
                chk("iss_pdest", n, 32'(iss_pdest_o), 32'(tbl[n].epd));
                chk("iss_psrc0", n, 32'(iss_psrc0_o), 32'(tbl[n].es0));
                chk("iss_psrc1", n, 32'(iss_psrc1_o), 32'(tbl[n].es1));
                chk("iss_oc",    n, iss_oc_o,          oc_of(tbl[n].epd));
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
